// File: rtl/image_pkg.sv
// image_pkg
//   Shared types and helpers for the image frame buffer and the raster scan
//   blocks built around it.
//   - state_t        : controller states (ST_IDLE, ST_INIT)
//   - INIT_GRADIENT  : init pattern where each pixel = row + col
//   - INIT_CONST     : init pattern where every pixel = a latched fill value
//   - gradient_sum() : row + col, returned wide so callers size it themselves
package image_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  localparam logic INIT_GRADIENT = 1'b0;
  localparam logic INIT_CONST    = 1'b1;

  function automatic int unsigned gradient_sum(input int unsigned r,
                                               input int unsigned c);
    return r + c;
  endfunction

endpackage

// File: rtl/image_init_scanner.sv
// image_init_scanner
//   Row-major raster counter. start clears to (0,0); advance steps one pixel,
//   wrapping the column into the next row and the last pixel back to (0,0).
//   Ports:
//     clk, rst_n  : clock, async active-low reset (counters -> 0)
//     start       : restart at (0,0); wins over advance
//     advance     : step to the next pixel
//     row, col    : current raster position
//     last        : current position is (last row, last col)
module image_init_scanner #(
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                advance,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] col,
  output logic                last
);

  logic col_last;
  logic row_last;

  assign col_last = &col;
  assign row_last = &row;
  assign last     = col_last && row_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (start) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      col <= col + 1'b1;
      if (col_last) begin
        row <= row + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_frame_buffer.sv
// image_frame_buffer
//   On-chip multi-channel pixel store with a per-channel write mask, a
//   registered read port and a built-in init engine (gradient or constant).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | user reads/writes serviced; init_start accepted
//   ST_INIT | one pixel per cycle written in raster order; user ignored
//
//   Ports:
//     clk, rst_n            : clock, async active-low reset
//     init_start/mode/value : start an init pass (sampled in ST_IDLE only)
//     busy                  : high for the whole init pass
//     row, col              : user pixel address
//     we, wmask, in         : masked write, channel k = in[k*CH_W +: CH_W]
//     re, out, out_valid    : read request, registered data, 1-cycle valid
module image_frame_buffer
  import image_pkg::*;
#(
  parameter int ROW_BITS      = 6,
  parameter int COL_BITS      = 6,
  parameter int CH_W          = 8,
  parameter int CHANNELS      = 3,
  parameter int INIT_ON_RESET = 1,
  localparam int PIX_W        = CH_W * CHANNELS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_start,
  input  logic                init_mode,
  input  logic [PIX_W-1:0]    init_value,
  output logic                busy,
  input  logic [ROW_BITS-1:0] row,
  input  logic [COL_BITS-1:0] col,
  input  logic                we,
  input  logic [CHANNELS-1:0] wmask,
  input  logic [PIX_W-1:0]    in,
  input  logic                re,
  output logic [PIX_W-1:0]    out,
  output logic                out_valid
);

  localparam int AW    = ROW_BITS + COL_BITS;
  localparam int GW    = AW + 1;
  localparam int DEPTH = 2 ** AW;

  state_t state_q, state_d;
  logic   mode_q;
  logic [PIX_W-1:0] value_q;

  logic                scan_start;
  logic                scan_adv;
  logic                scan_last;
  logic [ROW_BITS-1:0] scan_row;
  logic [COL_BITS-1:0] scan_col;

  logic [GW-1:0]    grad_sum;
  logic [PIX_W-1:0] init_pix;
  logic             idle;

  logic [PIX_W-1:0] mem [DEPTH];

  image_init_scanner #(
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_scanner (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (scan_start),
    .advance (scan_adv),
    .row     (scan_row),
    .col     (scan_col),
    .last    (scan_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_start = 1'b0;
    scan_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_start) begin
          state_d    = ST_INIT;
          scan_start = 1'b1;
        end
      end
      ST_INIT: begin
        scan_adv = 1'b1;
        if (scan_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset mode is gradient so the automatic pass after reset needs no request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= INIT_GRADIENT;
      value_q <= '0;
    end else if (state_q == ST_IDLE && init_start) begin
      mode_q  <= init_mode;
      value_q <= init_value;
    end
  end

  assign idle = (state_q == ST_IDLE);
  assign busy = !idle;

  // Sum carries one extra bit so (max row + max col) never wraps, then is
  // zero-extended or truncated to the whole pixel.
  assign grad_sum = GW'(gradient_sum(32'(scan_row), 32'(scan_col)));
  assign init_pix = (mode_q == INIT_CONST) ? value_q : PIX_W'(grad_sum);

  // Memory deliberately has no reset; contents come from the init engine.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[{scan_row, scan_col}] <= init_pix;
    end else if (we) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (wmask[k]) begin
          mem[{row, col}][k*CH_W +: CH_W] <= in[k*CH_W +: CH_W];
        end
      end
    end
  end

  // Non-blocking read of the same array gives read-first on a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= idle && re;
      if (idle && re) begin
        out <= mem[{row, col}];
      end
    end
  end

endmodule

// File: tb/tb_image_frame_buffer.sv
module tb_image_frame_buffer;
  localparam int RB = 2;
  localparam int CB = 3;
  localparam int CW = 8;
  localparam int CH = 3;
  localparam int PW = CW * CH;
  localparam int NPIX = 2 ** (RB + CB);
  localparam int NCOL = 2 ** CB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          init_start = 0, init_mode = 0;
  logic [PW-1:0] init_value = '0;
  logic [RB-1:0] row = '0;
  logic [CB-1:0] col = '0;
  logic          we = 0, re = 0;
  logic [CH-1:0] wmask = '0;
  logic [PW-1:0] in = '0;
  logic          busy, out_valid;
  logic [PW-1:0] out;

  logic          init_start0 = 0;
  logic          busy0, out_valid0;
  logic [PW-1:0] out0;

  image_frame_buffer #(.ROW_BITS(RB), .COL_BITS(CB), .CH_W(CW), .CHANNELS(CH),
                       .INIT_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_mode(init_mode),
    .init_value(init_value), .busy(busy), .row(row), .col(col), .we(we),
    .wmask(wmask), .in(in), .re(re), .out(out), .out_valid(out_valid));

  image_frame_buffer #(.ROW_BITS(RB), .COL_BITS(CB), .CH_W(CW), .CHANNELS(CH),
                       .INIT_ON_RESET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .init_start(init_start0), .init_mode(1'b0),
    .init_value('0), .busy(busy0), .row('0), .col('0), .we(1'b0),
    .wmask('0), .in('0), .re(1'b0), .out(out0), .out_valid(out_valid0));

  int checks = 0;
  int failures = 0;

  // reference image: pixel index = row*NCOL + col
  logic [PW-1:0] model [NPIX];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_gradient();
    for (int r = 0; r < 2 ** RB; r++)
      for (int c = 0; c < NCOL; c++)
        model[r*NCOL + c] = PW'(r + c);
  endtask

  task automatic model_write(input int r, input int c, input logic [CH-1:0] m,
                             input logic [PW-1:0] d);
    for (int k = 0; k < CH; k++)
      if (m[k]) model[r*NCOL + c][k*CW +: CW] = d[k*CW +: CW];
  endtask

  // count cycles of busy starting from the current sample
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic read_pix(input int r, input int c, input string name);
    logic [PW-1:0] exp;
    exp = model[r*NCOL + c];
    row = RB'(r); col = CB'(c); re = 1;
    step();
    re = 0;
    checks++;
    if (out_valid !== 1'b1 || out !== exp) begin
      failures++;
      $display("FAIL %s (%0d,%0d): out=%h valid=%b required out=%h valid=1",
               name, r, c, out, out_valid, exp);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 0;
    #12;
    checks++;
    if (busy !== 1'b1 || out !== '0 || out_valid !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b out=%h valid=%b busy0=%b required 1 0 0 0",
               busy, out, out_valid, busy0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    count_busy(n);
    model_gradient();
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL reset_init_len: busy cycles=%0d required 32", n);
    end
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy0=%b required 0", busy0);
    end
    read_pix(3, 7, "grad_3_7");
    checks++;
    if (model[31] !== 24'd10) begin
      failures++;
      $display("FAIL model_3_7: model=%h required 00000a", model[31]);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out !== 24'd10) begin
      failures++;
      $display("FAIL valid_pulse: valid=%b out=%h required valid=0 out=00000a",
               out_valid, out);
    end
  endtask

  task automatic test_masked_write();
    row = 1; col = 2; we = 1; wmask = 3'b010; in = 24'hAABBCC;
    step();
    we = 0;
    model_write(1, 2, 3'b010, 24'hAABBCC);
    read_pix(1, 2, "mask_mid");
    checks++;
    if (out !== 24'h00BB03) begin
      failures++;
      $display("FAIL mask_mid_const: out=%h required 00bb03", out);
    end
    row = 1; col = 2; we = 1; wmask = 3'b000; in = 24'h777777;
    step();
    we = 0;
    read_pix(1, 2, "mask_zero_noop");
  endtask

  task automatic test_read_write_same();
    row = 0; col = 0; we = 1; re = 1; wmask = 3'b111; in = 24'h123456;
    step();
    we = 0; re = 0;
    checks++;
    if (out_valid !== 1'b1 || out !== 24'h000000) begin
      failures++;
      $display("FAIL read_first: out=%h valid=%b required 000000 valid=1",
               out, out_valid);
    end
    model_write(0, 0, 3'b111, 24'h123456);
    read_pix(0, 0, "after_rw");
  endtask

  task automatic test_random();
    logic [PW-1:0] last_out, exp;
    logic          had_re;
    int            wr, wc, rr, rc;
    logic [CH-1:0] m;
    logic [PW-1:0] d;
    last_out = out;
    for (int i = 0; i < 80; i++) begin
      had_re = ($urandom_range(0, 3) != 0);
      rr = $urandom_range(0, 2 ** RB - 1);
      rc = $urandom_range(0, NCOL - 1);
      exp = model[rr*NCOL + rc];
      we = ($urandom_range(0, 1) == 1);
      re = had_re;
      if (had_re || !we) begin
        wr = rr; wc = rc;
      end else begin
        wr = $urandom_range(0, 2 ** RB - 1);
        wc = $urandom_range(0, NCOL - 1);
      end
      m = CH'($urandom);
      d = PW'($urandom);
      row = RB'(wr); col = CB'(wc); wmask = m; in = d;
      step();
      if (we) model_write(wr, wc, m, d);
      if (had_re) last_out = exp;
      checks++;
      if (out_valid !== had_re || out !== last_out) begin
        failures++;
        $display("FAIL random[%0d]: out=%h valid=%b required out=%h valid=%b",
                 i, out, out_valid, last_out, had_re);
      end
    end
    we = 0; re = 0;
    step();
  endtask

  task automatic test_const_init();
    logic [PW-1:0] hold;
    int n;
    int bad;
    hold = out;
    init_mode = 1; init_value = 24'h0F0F0F; init_start = 1;
    step();
    init_start = 0; init_value = 24'h333333;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      row = 0; col = 0; we = 1; re = 1; wmask = 3'b111; in = PW'($urandom);
      init_start = 1;
      step();
      n++;
      if (out_valid !== 1'b0 || out !== hold) bad++;
    end
    we = 0; re = 0; init_start = 0; init_mode = 0;
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL const_init_len: busy cycles=%0d required 32", n);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL busy_ignores_user: bad cycles=%0d required 0", bad);
    end
    for (int i = 0; i < NPIX; i++) model[i] = 24'h0F0F0F;
    for (int i = 0; i < NPIX; i++) read_pix(i / NCOL, i % NCOL, "const_fill");
  endtask

  task automatic test_reset_mid_init();
    int n;
    rst_n = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 10; i++) step();
    rst_n = 0;
    #2;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_reset: busy=%b required 1", busy);
    end
    @(posedge clk); #1;
    rst_n = 1;
    count_busy(n);
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL restart_len: busy cycles=%0d required 32", n);
    end
    model_gradient();
    read_pix(2, 5, "restart_2_5");
    read_pix(0, 0, "restart_0_0");
    read_pix(3, 7, "restart_3_7");
  endtask

  task automatic test_idle_start();
    int n;
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL idle0_start: busy0=%b required 0", busy0);
    end
    n = 0;
    for (int i = 0; i < 80; i++) begin
      init_start0 = (i == 0 || i == 3);
      step();
      if (busy0) n++;
    end
    init_start0 = 0;
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL single_pass: busy0 cycles=%0d required 32", n);
    end
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_read_write_same();
    test_random();
    test_const_init();
    test_reset_mid_init();
    test_idle_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
